// File: rtl/riscv_soft_lsu_if.sv
// riscv_soft_lsu_if: data-memory bus between the LSU and a word-organised memory.
//   master (LSU): drives dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be;
//                 samples dmem_ack, dmem_rdata.
//   slave (memory): the mirror image.
interface riscv_soft_lsu_if #(
  parameter int unsigned XPR_LEN = 32
);
  logic               dmem_req;
  logic               dmem_we;
  logic [XPR_LEN-1:0] dmem_addr;
  logic [XPR_LEN-1:0] dmem_wdata;
  logic [3:0]         dmem_be;
  logic               dmem_ack;
  logic [XPR_LEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/riscv_soft_lsu.sv
// riscv_soft_lsu: multi-cycle load/store unit for a small RISC-V pipeline.
//   clk, reset      : clock and asynchronous active-high reset
//   start           : pipeline presents an op (sampled only in IDLE)
//   mem_op          : 00 NOP, 01 LOAD, 10 STORE, 11 FENCE
//   mem_op_type     : funct3 width/sign code
//   addr/store_data : byte address and rs2 value
//   busy            : stall request, high whenever not IDLE
//   done/fault      : one-cycle completion / error pulses (mutually exclusive)
//   load_data       : extended load result, valid while done=1
//   dmem            : data-memory bus (master side)
module riscv_soft_lsu #(
  parameter int unsigned XPR_LEN      = 32,
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter int unsigned FENCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mem_op,
  input  logic [2:0]         mem_op_type,
  input  logic [XPR_LEN-1:0] addr,
  input  logic [XPR_LEN-1:0] store_data,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [XPR_LEN-1:0] load_data,
  riscv_soft_lsu_if.master   dmem
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StFence  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [XPR_LEN-1:0] addr_q, addr_d;
  logic [XPR_LEN-1:0] wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic [XPR_LEN-1:0] load_data_q, load_data_d;
  logic [2:0]         type_q, type_d;
  logic [1:0]         off_q, off_d;

  logic               is_load, is_store, type_ok, align_ok;
  logic [XPR_LEN-1:0] st_wdata;
  logic [3:0]         st_be;
  logic [XPR_LEN-1:0] rd_shift;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [XPR_LEN-1:0] rd_ext;

  // Decode and legality of the op presented on the pipeline side.
  always_comb begin
    is_load  = (mem_op == 2'b01);
    is_store = (mem_op == 2'b10);
    type_ok  = is_load  ? (mem_op_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) :
               is_store ? (mem_op_type inside {3'b000, 3'b001, 3'b010}) : 1'b0;
    case (mem_op_type[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    case (mem_op_type[1:0])
      2'b00: begin
        st_wdata = {(XPR_LEN/8){store_data[7:0]}};
        st_be    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {(XPR_LEN/16){store_data[15:0]}};
        st_be    = 4'b0011 << addr[1:0];
      end
      default: begin
        st_wdata = store_data;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Lane select and extension of returned read data.
  always_comb begin
    rd_shift = dmem.dmem_rdata >> {off_q, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (type_q)
      3'b000:  rd_ext = {{(XPR_LEN-8){rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{(XPR_LEN-16){rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {{(XPR_LEN-8){1'b0}}, rd_byte};
      3'b101:  rd_ext = {{(XPR_LEN-16){1'b0}}, rd_half};
      default: rd_ext = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    load_data_d = load_data_q;
    type_d      = type_q;
    off_d       = off_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (is_load || is_store) begin
            if (type_ok && align_ok) begin
              state_d = StAccess;
              cnt_d   = '0;
              req_d   = 1'b1;
              we_d    = is_store;
              addr_d  = {addr[XPR_LEN-1:2], 2'b00};
              wdata_d = is_store ? st_wdata : '0;
              be_d    = is_store ? st_be : 4'b1111;
              type_d  = mem_op_type;
              off_d   = addr[1:0];
            end else begin
              fault_d = 1'b1;
            end
          end else if (mem_op == 2'b11) begin
            state_d = StFence;
            cnt_d   = '0;
          end
        end
      end
      StAccess: begin
        if (dmem.dmem_ack || (cnt_q == ACK_TIMEOUT - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
          // Ack wins over a timeout landing in the same cycle.
          if (dmem.dmem_ack) begin
            done_d      = 1'b1;
            load_data_d = we_q ? '0 : rd_ext;
          end else begin
            fault_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StFence: begin
        if (cnt_q == FENCE_CYCLES - 1) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      type_q      <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      type_q      <= type_d;
      off_q       <= off_d;
    end
  end

  assign busy            = (state_q != StIdle);
  assign done            = done_q;
  assign fault           = fault_q;
  assign load_data       = load_data_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

endmodule

// File: tb/tb_riscv_soft_lsu.sv
module tb_riscv_soft_lsu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mem_op = 2'b00;
  logic [2:0]  mem_op_type = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, fault;
  logic [31:0] load_data;

  int errors = 0;
  int checks = 0;

  riscv_soft_lsu_if #(.XPR_LEN(32)) dmem_if ();

  riscv_soft_lsu #(
    .XPR_LEN(32),
    .ACK_TIMEOUT(8),
    .FENCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mem_op(mem_op),
    .mem_op_type(mem_op_type),
    .addr(addr),
    .store_data(store_data),
    .busy(busy),
    .done(done),
    .fault(fault),
    .load_data(load_data),
    .dmem(dmem_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] typ, input logic [31:0] a,
                       input logic [31:0] sd);
    start = 1'b1; mem_op = op; mem_op_type = typ; addr = a; store_data = sd;
  endtask

  // Load acked on its first ACCESS cycle.
  task automatic do_load(input string tag, input logic [2:0] typ, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    issue(2'b01, typ, a, 32'h0);
    dmem_if.dmem_rdata = rd;
    dmem_if.dmem_ack = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_req"}, {31'd0, dmem_if.dmem_req}, 32'd1);
    chk({tag, "_addr"}, dmem_if.dmem_addr, {a[31:2], 2'b00});
    step();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_data"}, load_data, exp);
    dmem_if.dmem_ack = 1'b0;
    step();
  endtask

  initial begin
    dmem_if.dmem_ack = 1'b0;
    dmem_if.dmem_rdata = '0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_fault", {30'd0, done, fault}, 32'd0);
    chk("rst_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    chk("rst_bus", dmem_if.dmem_addr | dmem_if.dmem_wdata | {28'd0, dmem_if.dmem_be}, 32'd0);
    chk("rst_ld", load_data, 32'd0);

    // LB at 0x103, start accepted on the first edge after reset release
    reset = 1'b0;
    issue(2'b01, 3'b000, 32'h103, 32'h0);
    dmem_if.dmem_rdata = 32'h80FF_FF7F;
    dmem_if.dmem_ack = 1'b1;
    step();
    start = 1'b0;
    chk("lb_req", {31'd0, dmem_if.dmem_req}, 32'd1);
    chk("lb_we", {31'd0, dmem_if.dmem_we}, 32'd0);
    chk("lb_addr", dmem_if.dmem_addr, 32'h100);
    chk("lb_be", {28'd0, dmem_if.dmem_be}, 32'hF);
    chk("lb_busy", {31'd0, busy}, 32'd1);
    chk("lb_nodone", {31'd0, done}, 32'd0);
    step();
    chk("lb_done", {31'd0, done}, 32'd1);
    chk("lb_fault", {31'd0, fault}, 32'd0);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_req_off", {31'd0, dmem_if.dmem_req}, 32'd0);
    chk("lb_busy_off", {31'd0, busy}, 32'd0);
    dmem_if.dmem_ack = 1'b0;
    step();
    chk("lb_done_pulse", {31'd0, done}, 32'd0);

    do_load("lhu", 3'b101, 32'h1002, 32'h8765_4321, 32'h0000_8765);
    do_load("lh", 3'b001, 32'h1000, 32'h1234_F00D, 32'hFFFF_F00D);
    do_load("lbu", 3'b100, 32'h0005, 32'h0000_9A00, 32'h0000_009A);
    do_load("lw", 3'b010, 32'h0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // SH at 0x22, ack delayed two cycles: bus must hold steady
    issue(2'b10, 3'b001, 32'h22, 32'h1234_ABCD);
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", {31'd0, dmem_if.dmem_req}, 32'd1);
      chk("sh_we", {31'd0, dmem_if.dmem_we}, 32'd1);
      chk("sh_addr", dmem_if.dmem_addr, 32'h20);
      chk("sh_be", {28'd0, dmem_if.dmem_be}, 32'hC);
      chk("sh_wdata", dmem_if.dmem_wdata, 32'hABCD_ABCD);
      if (i == 2) dmem_if.dmem_ack = 1'b1;
      step();
    end
    dmem_if.dmem_ack = 1'b0;
    chk("sh_done", {31'd0, done}, 32'd1);
    chk("sh_ld_zero", load_data, 32'd0);
    chk("sh_we_off", {30'd0, dmem_if.dmem_we, dmem_if.dmem_req}, 32'd0);
    step();

    // SB at 0x7
    issue(2'b10, 3'b000, 32'h7, 32'h1122_3344);
    dmem_if.dmem_ack = 1'b1;
    step();
    start = 1'b0;
    chk("sb_be", {28'd0, dmem_if.dmem_be}, 32'h8);
    chk("sb_wdata", dmem_if.dmem_wdata, 32'h4444_4444);
    chk("sb_addr", dmem_if.dmem_addr, 32'h4);
    step();
    chk("sb_done", {31'd0, done}, 32'd1);
    dmem_if.dmem_ack = 1'b0;
    step();

    // Misaligned LW at 0x41
    issue(2'b01, 3'b010, 32'h41, 32'h0);
    step();
    start = 1'b0;
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_done", {31'd0, done}, 32'd0);
    chk("mis_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    chk("mis_busy", {31'd0, busy}, 32'd0);
    step();
    chk("mis_pulse", {31'd0, fault}, 32'd0);

    // Illegal store type 100, then misaligned SH at 0x3
    issue(2'b10, 3'b100, 32'h10, 32'h0);
    step();
    chk("ilst_fault", {31'd0, fault}, 32'd1);
    chk("ilst_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    issue(2'b10, 3'b001, 32'h3, 32'h0);
    step();
    start = 1'b0;
    chk("missh_fault", {31'd0, fault}, 32'd1);
    chk("missh_busy", {31'd0, busy}, 32'd0);
    // Illegal load type 011
    issue(2'b01, 3'b011, 32'h0, 32'h0);
    step();
    start = 1'b0;
    chk("illd_fault", {31'd0, fault}, 32'd1);
    step();

    // NOP
    issue(2'b00, 3'b010, 32'h0, 32'h0);
    step();
    start = 1'b0;
    chk("nop_state", {29'd0, busy, done, fault}, 32'd0);
    chk("nop_req", {31'd0, dmem_if.dmem_req}, 32'd0);

    // LW with no ack: eight request cycles then timeout fault
    issue(2'b01, 3'b010, 32'h80, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      start = 1'b0;
      chk("to_req", {31'd0, dmem_if.dmem_req}, 32'd1);
      chk("to_busy_nofault", {30'd0, busy, fault}, 32'h2);
    end
    step();
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_done", {31'd0, done}, 32'd0);
    chk("to_req_off", {31'd0, dmem_if.dmem_req}, 32'd0);
    chk("to_busy_off", {31'd0, busy}, 32'd0);
    step();
    chk("to_pulse", {31'd0, fault}, 32'd0);

    // FENCE with start held, switching to a LOAD that must be ignored
    issue(2'b11, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 1) mem_op = 2'b01;
      if (i == 3) start = 1'b0;
      chk("fence_busy", {31'd0, busy}, 32'd1);
      chk("fence_nodone", {31'd0, done}, 32'd0);
      chk("fence_noreq", {31'd0, dmem_if.dmem_req}, 32'd0);
    end
    step();
    chk("fence_done", {31'd0, done}, 32'd1);
    chk("fence_idle", {31'd0, busy}, 32'd0);
    step();
    chk("fence_one_pulse", {30'd0, done, busy}, 32'd0);
    chk("fence_noreq2", {31'd0, dmem_if.dmem_req}, 32'd0);

    // Reset mid-ACCESS, checked between clock edges
    issue(2'b01, 3'b010, 32'h10, 32'h0);
    step();
    start = 1'b0;
    chk("mid_req", {31'd0, dmem_if.dmem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_async_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    chk("mid_async_busy", {31'd0, busy}, 32'd0);
    dmem_if.dmem_ack = 1'b1;
    #1 reset = 1'b0;
    step();
    chk("mid_nodone", {29'd0, done, fault, busy}, 32'd0);
    chk("mid_noreq", {31'd0, dmem_if.dmem_req}, 32'd0);
    step();
    chk("mid_nodone2", {31'd0, done}, 32'd0);
    dmem_if.dmem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so a stuck simulation still reports.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
